// File: rtl/iline_read_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : iline_read_responder_if
//  Brief    : ICache line read bus plus word-memory fetch bus bundle.
//             "slave" is the responder view, "master" is the cache/memory
//             environment view.
//  Revision : 1.0  initial release
// ============================================================================
interface iline_read_responder_if #(
    parameter int WORDS = 4
);
    localparam int CACHE_BLK_SIZE = 32 * WORDS;

    // Cache side
    logic [3:0]                cpu_ren;
    logic [31:0]               cpu_raddr;
    logic                      dev_rrdy;
    logic                      dev_rvalid;
    logic [CACHE_BLK_SIZE-1:0] dev_rdata;
    logic                      req_drop;

    // Word memory side
    logic                      mem_ren;
    logic [31:0]               mem_raddr;
    logic                      mem_rvalid;
    logic [31:0]               mem_rdata;

    modport slave (
        input  cpu_ren, cpu_raddr, mem_rvalid, mem_rdata,
        output dev_rrdy, dev_rvalid, dev_rdata, req_drop, mem_ren, mem_raddr
    );

    modport master (
        output cpu_ren, cpu_raddr, mem_rvalid, mem_rdata,
        input  dev_rrdy, dev_rvalid, dev_rdata, req_drop, mem_ren, mem_raddr
    );
endinterface
`default_nettype wire

// File: rtl/iline_read_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : iline_read_responder
//  Brief    : Accepts an ICache line read, fetches the line one 32-bit word
//             at a time from word memory (one word outstanding), assembles
//             it and returns it with a single-cycle dev_rvalid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module iline_read_responder #(
    parameter int WORDS       = 4,
    parameter int OFFSET_BITS = 4
) (
    input  wire logic             cpu_clk,
    input  wire logic             cpu_rst,
    iline_read_responder_if.slave bus
);
    localparam int CACHE_BLK_SIZE = 32 * WORDS;
    localparam int CW             = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [31:0]               base;
    logic [31:0]               base_next;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_next;
    logic [CACHE_BLK_SIZE-1:0] line;
    logic [CACHE_BLK_SIZE-1:0] line_next;
    logic [CACHE_BLK_SIZE-1:0] rdata;
    logic                      rdata_load;
    logic [31:0]               raddr;
    logic [31:0]               raddr_next;
    logic                      drop;
    logic                      req_seen;

    // The byte offset inside the line is discarded: the whole line is fetched.
    logic unused_offset;
    assign unused_offset = ^bus.cpu_raddr[OFFSET_BITS-1:0];

    assign req_seen = |bus.cpu_ren;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the line-assembly datapath decisions.
    always_comb begin
        state_next = state;
        base_next  = base;
        count_next = count;
        line_next  = line;
        rdata_load = 1'b0;
        case (state)
            IDLE: begin
                if (req_seen) begin
                    base_next  = {bus.cpu_raddr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    count_next = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    line_next[{count, 5'b00000} +: 32] = bus.mem_rdata;
                    if (count == LAST_WORD) begin
                        rdata_load = 1'b1;
                        state_next = RESP;
                    end else begin
                        count_next = count + 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Word address for the upcoming ISSUE cycle, modulo 2^32.
        raddr_next = base_next + 32'({count_next, 2'b00});
    end

    // Datapath registers: line buffer, output line, word address, drop pulse.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            base  <= '0;
            count <= '0;
            line  <= '0;
            rdata <= '0;
            raddr <= '0;
            drop  <= 1'b0;
        end else begin
            base  <= base_next;
            count <= count_next;
            line  <= line_next;
            if (rdata_load) begin
                rdata <= line_next;
            end
            if (state_next == ISSUE) begin
                raddr <= raddr_next;
            end
            drop <= (state != IDLE) && req_seen;
        end
    end

    assign bus.dev_rrdy   = (state == IDLE);
    assign bus.dev_rvalid = (state == RESP);
    assign bus.mem_ren    = (state == ISSUE);
    assign bus.mem_raddr  = raddr;
    assign bus.dev_rdata  = rdata;
    assign bus.req_drop   = drop;
endmodule
`default_nettype wire

// File: tb/tb_iline_read_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_iline_read_responder
//  Brief    : Self-checking bench: word memory model with programmable
//             per-word latency, expected-address and expected-line queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iline_read_responder;
    localparam int WORDS = 4;
    localparam int LW    = 32 * WORDS;

    logic cpu_clk = 1'b0;
    logic cpu_rst;

    iline_read_responder_if #(.WORDS(WORDS)) bus ();

    iline_read_responder #(
        .WORDS       (WORDS),
        .OFFSET_BITS (4)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [3:0]  ren;
        logic [31:0] addr;
        int          lat0;
        int          lat1;
        int          lat2;
        int          lat3;
        logic [31:0] salt;
        logic [31:0] exp_base;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[4];

    int checks = 0;
    int errors = 0;

    logic [31:0]   exp_addr_q[$];
    logic [LW-1:0] exp_line_q[$];
    logic [LW-1:0] exp_last;

    int          lat_pat[4];
    int          widx;
    int          cd;
    logic [31:0] pend_addr;
    logic [31:0] salt;
    int          n_ren, n_valid, n_drop, n_rv;
    bit          hold_en;
    int          hold_bad;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a + 32'h0000_00A0) ^ salt;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < WORDS; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            l[32*i +: 32] = memf(base + 32'(4 * i));
        end
        exp_line_q.push_back(l);
    endtask

    // One cycle: advance to the falling edge, run memory model and monitors.
    task automatic tick();
        @(negedge cpu_clk);
        bus.mem_rvalid = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = memf(pend_addr);
                n_rv++;
            end
        end
        if (bus.mem_ren) begin
            n_ren++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_ren addr %h", bus.mem_raddr);
            end else begin
                chk("mem_raddr", LW'(bus.mem_raddr), LW'(exp_addr_q.pop_front()));
            end
            pend_addr = bus.mem_raddr;
            cd        = lat_pat[widx];
            widx      = (widx + 1) % WORDS;
        end
        if (bus.dev_rvalid) begin
            n_valid++;
            if (exp_line_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dev_rvalid data %h", bus.dev_rdata);
            end else begin
                exp_last = exp_line_q.pop_front();
                chk("dev_rdata", bus.dev_rdata, exp_last);
            end
        end else if (hold_en && (bus.dev_rdata !== exp_last)) begin
            hold_bad++;
        end
        if (bus.req_drop) n_drop++;
    endtask

    task automatic do_req(input logic [3:0] ren, input logic [31:0] addr);
        bus.cpu_ren   = ren;
        bus.cpu_raddr = addr;
        tick();
        bus.cpu_ren   = 4'h0;
        bus.cpu_raddr = 32'h0;
    endtask

    task automatic wait_resp(input string name, input int exp_k);
        int k;
        int v0;
        k  = 0;
        v0 = n_valid;
        while (n_valid == v0 && k < 300) begin
            tick();
            k++;
        end
        if (n_valid == v0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no dev_rvalid within %0d cycles", name, k);
        end else if (exp_k >= 0) begin
            chk({name, "_latency"}, LW'(k), LW'(exp_k));
        end
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat_pat[0] = a;
        lat_pat[1] = b;
        lat_pat[2] = c;
        lat_pat[3] = d;
        widx       = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, v0, d0, k;

        vecs[0] = '{4'hF, 32'h0000_1234, 1, 1, 1, 1, 32'h0000_0000, 32'h0000_1230, 8};
        vecs[1] = '{4'h1, 32'h0000_ABC8, 1, 5, 2, 3, 32'h5A5A_0000, 32'h0000_ABC0, 15};
        vecs[2] = '{4'h8, 32'hFFFF_FFFC, 2, 1, 1, 2, 32'h0F0F_0F0F, 32'hFFFF_FFF0, 10};
        vecs[3] = '{4'h2, 32'h0000_0040, 3, 3, 3, 3, 32'h1234_5678, 32'h0000_0040, 16};

        cpu_rst        = 1'b1;
        bus.cpu_ren    = 4'h0;
        bus.cpu_raddr  = 32'h0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        cd = 0; n_ren = 0; n_valid = 0; n_drop = 0; n_rv = 0;
        hold_en = 1'b0; hold_bad = 0; salt = 32'h0; exp_last = '0;
        set_lat(1, 1, 1, 1);

        // Reset state
        tick();
        tick();
        chk("rst_dev_rrdy",   LW'(bus.dev_rrdy),   LW'(1));
        chk("rst_dev_rvalid", LW'(bus.dev_rvalid), LW'(0));
        chk("rst_dev_rdata",  bus.dev_rdata,       '0);
        chk("rst_mem_ren",    LW'(bus.mem_ren),    LW'(0));
        chk("rst_mem_raddr",  LW'(bus.mem_raddr),  LW'(0));
        chk("rst_req_drop",   LW'(bus.req_drop),   LW'(0));
        cpu_rst = 1'b0;
        tick();

        // Table-driven lines with assorted latencies and addresses
        for (int i = 0; i < 4; i++) begin
            set_lat(vecs[i].lat0, vecs[i].lat1, vecs[i].lat2, vecs[i].lat3);
            salt = vecs[i].salt;
            r0 = n_ren; v0 = n_valid; d0 = n_drop;
            push_line(vecs[i].exp_base);
            do_req(vecs[i].ren, vecs[i].addr);
            chk($sformatf("vec%0d_busy_rrdy", i), LW'(bus.dev_rrdy), LW'(0));
            wait_resp($sformatf("vec%0d", i), vecs[i].exp_cyc);
            chk($sformatf("vec%0d_ren_count", i), LW'(n_ren - r0), LW'(4));
            tick();
            chk($sformatf("vec%0d_rrdy_after", i),   LW'(bus.dev_rrdy),   LW'(1));
            chk($sformatf("vec%0d_rvalid_pulse", i), LW'(bus.dev_rvalid), LW'(0));
            chk($sformatf("vec%0d_valid_count", i),  LW'(n_valid - v0),   LW'(1));
            chk($sformatf("vec%0d_no_drop", i),      LW'(n_drop - d0),    LW'(0));
        end

        // Request while busy is dropped with a single req_drop pulse
        set_lat(3, 3, 3, 3);
        salt = 32'h0000_0000;
        r0 = n_ren; v0 = n_valid; d0 = n_drop;
        push_line(32'h0000_1000);
        do_req(4'hF, 32'h0000_1000);
        tick();
        do_req(4'hF, 32'h0000_2000);
        wait_resp("busy", -1);
        repeat (3) tick();
        chk("busy_drop_count",  LW'(n_drop - d0),        LW'(1));
        chk("busy_ren_count",   LW'(n_ren - r0),         LW'(4));
        chk("busy_valid_count", LW'(n_valid - v0),       LW'(1));
        chk("busy_addr_q",      LW'(exp_addr_q.size()),  LW'(0));

        // Reset mid-transfer after the second word
        set_lat(1, 1, 4, 1);
        salt = 32'h0BAD_0000;
        push_line(32'h0000_3000);
        do_req(4'hF, 32'h0000_3000);
        k = 0;
        while (n_rv < 2 + 0 * k && k < 50) begin
            tick();
            k++;
        end
        tick();
        cpu_rst = 1'b1;
        #1;
        chk("mid_rst_dev_rrdy",   LW'(bus.dev_rrdy),   LW'(1));
        chk("mid_rst_dev_rvalid", LW'(bus.dev_rvalid), LW'(0));
        chk("mid_rst_dev_rdata",  bus.dev_rdata,       '0);
        chk("mid_rst_mem_ren",    LW'(bus.mem_ren),    LW'(0));
        chk("mid_rst_mem_raddr",  LW'(bus.mem_raddr),  LW'(0));
        exp_addr_q.delete();
        exp_line_q.delete();
        v0 = n_valid;
        tick();
        cpu_rst = 1'b0;
        repeat (6) tick();
        chk("late_rvalid_ignored", LW'(n_valid - v0),   LW'(0));
        chk("late_rvalid_rrdy",    LW'(bus.dev_rrdy),   LW'(1));
        chk("late_rvalid_rdata",   bus.dev_rdata,       '0);
        set_lat(1, 1, 1, 1);
        salt = 32'h0000_0000;
        push_line(32'h0000_0040);
        do_req(4'hF, 32'h0000_0040);
        wait_resp("post_rst", 8);
        tick();

        // Back-to-back: second request on the first ready cycle after RESP
        set_lat(1, 1, 1, 1);
        salt = 32'h1111_0000;
        push_line(32'h0000_0500);
        do_req(4'hF, 32'h0000_0504);
        wait_resp("b2b_first", 8);
        tick();
        chk("b2b_rrdy", LW'(bus.dev_rrdy), LW'(1));
        salt = 32'h2222_0000;
        d0 = n_drop;
        push_line(32'h0000_0600);
        hold_en  = 1'b1;
        hold_bad = 0;
        do_req(4'h3, 32'h0000_0608);
        chk("b2b_accepted", LW'(bus.dev_rrdy), LW'(0));
        wait_resp("b2b_second", 8);
        hold_en = 1'b0;
        chk("b2b_rdata_stable", LW'(hold_bad),     LW'(0));
        chk("b2b_no_drop",      LW'(n_drop - d0),  LW'(0));
        tick();
        chk("final_line_q", LW'(exp_line_q.size()), LW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/iline_read_responder.md
Name: iline_read_responder

Overview:
Memory-side responder on the ICache read bus. It accepts a line read request (cpu_ren/cpu_raddr), fetches the line one word at a time from a 32-bit word memory, assembles a CACHE_BLK_SIZE-bit line, and returns it with a one-cycle dev_rvalid pulse. It sits between the instruction cache refill port and the instruction word memory/bridge.

Parameters:
WORDS, 4, 32-bit words per line; CACHE_BLK_SIZE = 32*WORDS (128 at default)
OFFSET_BITS, 4, byte-offset bits cleared for line alignment (log2(WORDS*4))

Ports:
cpu_clk  in  1  clock, all state updates on rising edge
cpu_rst  in  1  reset, asynchronous, active-high
cpu_ren  in  4  read enable from cache; nonzero = line request
cpu_raddr  in  32  request byte address
dev_rrdy  out  1  responder idle, can accept a request
dev_rvalid  out  1  one-cycle pulse, line data valid
dev_rdata  out  CACHE_BLK_SIZE  assembled line
mem_ren  out  1  word read strobe to word memory, one cycle
mem_raddr  out  32  word byte address
mem_rvalid  in  1  word memory data valid
mem_rdata  in  32  word memory data
req_drop  out  1  one-cycle pulse: request arrived while busy and was dropped

Behaviour:
- Reset (asynchronous, cpu_rst=1): state IDLE, dev_rrdy=1, dev_rvalid=0, dev_rdata=0, mem_ren=0, mem_raddr=0, req_drop=0, word counter=0. Reset mid-transfer abandons the transfer; no dev_rvalid is issued for it.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE: dev_rrdy=1. On an edge with cpu_ren!=0, latch base = {cpu_raddr[31:OFFSET_BITS], OFFSET_BITS'b0}, clear the counter, and go to ISSUE. Any nonzero cpu_ren fetches the full line.
- ISSUE (one cycle): mem_ren=1, mem_raddr = base + 4*count. Go to WAIT.
- WAIT: mem_ren=0. Hold until mem_rvalid. On mem_rvalid, write mem_rdata into line bits [32*count +: 32]. If count==WORDS-1, go to RESP. Otherwise increment count and go to ISSUE.
- RESP (one cycle): dev_rvalid=1 and dev_rdata = the assembled line. Go to IDLE.
- dev_rdata holds its value after RESP until the next RESP. Word i of the line is the word at base+4i (offset field [3:2] selects bits [32*i +: 32]).
- dev_rrdy=0 in ISSUE, WAIT and RESP. It returns to 1 the cycle after RESP.
- A nonzero cpu_ren in a non-IDLE state is dropped and pulses req_drop for one cycle. The current transfer is unaffected.
- mem_rvalid outside WAIT, including after reset, is ignored.
- Only one word is outstanding at a time. The word memory latency is ≥1 cycle after mem_ren and is unbounded; there is no timeout.
- Address arithmetic is 32-bit modulo. A line at 0xFFFFFFF0 produces word addresses 0xFFFFFFF0..0xFFFFFFFC with no wrap inside the line.
- Latency with a 1-cycle memory: request accepted at edge E0, mem_ren on cycles 1, 3, 5, 7, mem_rvalid on cycles 2, 4, 6, 8, dev_rvalid on cycle 9, dev_rrdy=1 on cycle 10.

Test Plan:
- Basic line: cpu_ren=F, cpu_raddr=0x0000_1234, memory returns 0xA0+addr, latency 1 -> mem_raddr 0x1230, 0x1234, 0x1238, 0x123C; dev_rvalid on cycle 9; dev_rdata = {0x123C+A0, 0x1238+A0, 0x1234+A0, 0x1230+A0} (MSW..LSW).
- Variable latency: mem_rvalid delays of 1, 5, 2, 3 cycles -> exactly 4 mem_ren pulses, correct word order, a single dev_rvalid pulse, then dev_rrdy=1 the next cycle.
- Busy request: second cpu_ren=F at 0x2000 during WAIT of the first line -> req_drop pulses once; only the first line is returned; no fetch from 0x2000.
- Reset mid-transfer: cpu_rst asserted after the 2nd word -> all outputs go to reset values immediately; a late mem_rvalid is ignored; a new request at 0x40 afterwards returns a correct line.
- Boundary address: cpu_raddr=0xFFFF_FFFC -> base 0xFFFF_FFF0; words read from 0xFFFFFFF0..0xFFFFFFFC.
- Back-to-back: a second request issued on the first cycle dev_rrdy=1 after RESP -> accepted with no req_drop; dev_rdata from the first line is stable until the second RESP.
